spi_cmd_queue: RTL and testbench

//   Command/response buffer directly upstream of SPIMaster. The bus side pushes
//   {rw, byte} commands into a TX FIFO. An FSM pops each command, launches it on

---
 rtl/spi_cmd_queue.sv | 212 +++++++++++++++++++++
 tb/tb_spi_cmd_queue.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_queue
// Purpose  : Command/response buffer in front of an SPI shift engine. Bus-side
//            {rw, byte} commands queue in a TX FIFO. A sequencer launches each
//            command on the engine and stores read results in an RX FIFO.
// Ports    : clk_i/rst_i       clock, async active-high reset
//            clr_i             sync clear of FIFOs, sticky flags and sequencer
//            tx_wr_i/tx_rw_i/tx_data_i, tx_full_o, tx_level_o   command side
//            rx_rd_i, rx_data_o, rx_empty_o, rx_overflow_o       result side
//            timeout_o, busy_o                                   status
//            spi_rw_o/spi_start_o/spi_tx_data_o, spi_done_i/spi_rx_data_i
//                                                                engine side
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_queue #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   tx_wr_i,
    input  logic                   tx_rw_i,
    input  logic [7:0]             tx_data_i,
    output logic                   tx_full_o,
    output logic [$clog2(DEPTH):0] tx_level_o,
    input  logic                   rx_rd_i,
    output logic [7:0]             rx_data_o,
    output logic                   rx_empty_o,
    output logic                   rx_overflow_o,
    output logic                   timeout_o,
    output logic                   busy_o,
    output logic                   spi_rw_o,
    output logic                   spi_start_o,
    output logic [7:0]             spi_tx_data_o,
    input  logic                   spi_done_i,
    input  logic [7:0]             spi_rx_data_i
);

    localparam int C_AW = $clog2(DEPTH);
    localparam int C_LW = C_AW + 1;
    localparam int C_TW = $clog2(TIMEOUT + 1);
    localparam logic [C_LW-1:0] C_DEPTH = C_LW'(DEPTH);
    // Abort happens on the edge that would take the counter to TIMEOUT.
    localparam logic [C_TW-1:0] C_TLAST = C_TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_BUSY    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    logic [8:0] tx_mem [DEPTH];
    logic [7:0] rx_mem [DEPTH];

    logic [C_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [C_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [C_LW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    state_t          state_q, state_d;
    logic [C_TW-1:0] tmo_q, tmo_d;
    logic            spi_start_q, spi_start_d;
    logic            spi_rw_q, spi_rw_d;
    logic [7:0]      spi_data_q, spi_data_d;
    logic            ovf_q, ovf_d;
    logic            tflag_q, tflag_d;

    logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;

    assign w_tx_full  = (tx_cnt_q == C_DEPTH);
    assign w_tx_empty = (tx_cnt_q == '0);
    assign w_rx_full  = (rx_cnt_q == C_DEPTH);
    assign w_rx_empty = (rx_cnt_q == '0);

    // Full check deliberately ignores a same-cycle pop.
    assign w_tx_push = tx_wr_i && !w_tx_full && !clr_i;
    assign w_rx_pop  = rx_rd_i && !w_rx_empty && !clr_i;

    // Sequencer next-state
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        spi_start_d = spi_start_q;
        spi_rw_d    = spi_rw_q;
        spi_data_d  = spi_data_q;
        ovf_d       = ovf_q;
        tflag_d     = tflag_q;
        w_tx_pop    = 1'b0;
        w_rx_push   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Launch only once the engine reports idle; this also covers
                // an engine still finishing a transfer abandoned by clr_i.
                if (!w_tx_empty && spi_done_i) begin
                    w_tx_pop    = 1'b1;
                    spi_data_d  = tx_mem[tx_rp_q][7:0];
                    spi_rw_d    = tx_mem[tx_rp_q][8];
                    spi_start_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = S_START;
                end
            end
            S_START, S_BUSY: begin
                tmo_d = tmo_q + C_TW'(1);
                if (tmo_q == C_TLAST) begin
                    tflag_d     = 1'b1;
                    spi_start_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (state_q == S_START && !spi_done_i) begin
                    spi_start_d = 1'b0;
                    state_d     = S_BUSY;
                end else if (state_q == S_BUSY && spi_done_i) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (spi_rw_q) begin
                    if (w_rx_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        w_rx_push = 1'b1;
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (clr_i) begin
            state_d     = S_IDLE;
            spi_start_d = 1'b0;
            ovf_d       = 1'b0;
            tflag_d     = 1'b0;
            w_tx_pop    = 1'b0;
            w_rx_push   = 1'b0;
        end
    end

    // FIFO pointer/level next-state
    always_comb begin
        tx_wp_d  = tx_wp_q + C_AW'(w_tx_push);
        tx_rp_d  = tx_rp_q + C_AW'(w_tx_pop);
        tx_cnt_d = tx_cnt_q + C_LW'(w_tx_push) - C_LW'(w_tx_pop);
        rx_wp_d  = rx_wp_q + C_AW'(w_rx_push);
        rx_rp_d  = rx_rp_q + C_AW'(w_rx_pop);
        rx_cnt_d = rx_cnt_q + C_LW'(w_rx_push) - C_LW'(w_rx_pop);
        if (clr_i) begin
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_cnt_d = '0;
            rx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            spi_start_q <= 1'b0;
            spi_rw_q    <= 1'b0;
            spi_data_q  <= '0;
            ovf_q       <= 1'b0;
            tflag_q     <= 1'b0;
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
            tx_cnt_q    <= '0;
            rx_wp_q     <= '0;
            rx_rp_q     <= '0;
            rx_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            spi_start_q <= spi_start_d;
            spi_rw_q    <= spi_rw_d;
            spi_data_q  <= spi_data_d;
            ovf_q       <= ovf_d;
            tflag_q     <= tflag_d;
            tx_wp_q     <= tx_wp_d;
            tx_rp_q     <= tx_rp_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wp_q     <= rx_wp_d;
            rx_rp_q     <= rx_rp_d;
            rx_cnt_q    <= rx_cnt_d;
        end
    end

    // Storage arrays need no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk_i) begin
        if (w_tx_push) begin
            tx_mem[tx_wp_q] <= {tx_rw_i, tx_data_i};
        end
        if (w_rx_push) begin
            rx_mem[rx_wp_q] <= spi_rx_data_i;
        end
    end

    assign tx_full_o     = w_tx_full;
    assign tx_level_o    = tx_cnt_q;
    assign rx_data_o     = rx_mem[rx_rp_q];
    assign rx_empty_o    = w_rx_empty;
    assign rx_overflow_o = ovf_q;
    assign timeout_o     = tflag_q;
    assign busy_o        = (state_q != S_IDLE);
    assign spi_rw_o      = spi_rw_q;
    assign spi_start_o   = spi_start_q;
    assign spi_tx_data_o = spi_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cmd_queue
// Purpose  : Self-checking bench for spi_cmd_queue with a behavioural SPI
//            engine model, a vector table, directed corner sequences and a
//            randomized run checked against an in-order command/result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_queue;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 40;

    logic       clk_i = 1'b0;
    logic       rst_i, clr_i, tx_wr_i, tx_rw_i, rx_rd_i;
    logic [7:0] tx_data_i;
    logic       tx_full_o, rx_empty_o, rx_overflow_o, timeout_o, busy_o;
    logic [3:0] tx_level_o;
    logic [7:0] rx_data_o, spi_tx_data_o;
    logic       spi_rw_o, spi_start_o;
    logic       spi_done_i = 1'b1;
    logic [7:0] spi_rx_data_i = 8'h00;

    always #5 clk_i = ~clk_i;

    spi_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
        .tx_wr_i(tx_wr_i), .tx_rw_i(tx_rw_i), .tx_data_i(tx_data_i),
        .tx_full_o(tx_full_o), .tx_level_o(tx_level_o),
        .rx_rd_i(rx_rd_i), .rx_data_o(rx_data_o), .rx_empty_o(rx_empty_o),
        .rx_overflow_o(rx_overflow_o), .timeout_o(timeout_o), .busy_o(busy_o),
        .spi_rw_o(spi_rw_o), .spi_start_o(spi_start_o), .spi_tx_data_o(spi_tx_data_o),
        .spi_done_i(spi_done_i), .spi_rx_data_i(spi_rx_data_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- SPI engine model ----------------
    typedef struct { logic rw; logic [7:0] data; logic [7:0] rx; } launch_t;
    launch_t    launch_q[$];
    logic       m_hold = 1'b0;      // accept but never finish
    logic       m_noaccept = 1'b0;  // never accept a launch
    logic       m_busy = 1'b0;
    logic       m_rand_lat = 1'b0;
    int         m_lat = 4;
    int         m_cnt = 0;
    int         m_rx_mode = 0;      // 0 fixed, 1 random, 2 inverted tx byte
    logic [7:0] m_fixed_rx = 8'h00;
    logic [7:0] m_rx = 8'h00;

    always @(negedge clk_i) begin
        if (rst_i) begin
            m_busy     = 1'b0;
            spi_done_i = 1'b1;
        end else if (!m_busy) begin
            if (spi_start_o && spi_done_i && !m_noaccept) begin
                m_busy     = 1'b1;
                spi_done_i = 1'b0;
                m_cnt      = m_rand_lat ? int'($urandom_range(1, 12)) : m_lat;
                case (m_rx_mode)
                    0:       m_rx = m_fixed_rx;
                    1:       m_rx = 8'($urandom);
                    default: m_rx = ~spi_tx_data_o;
                endcase
                launch_q.push_back('{spi_rw_o, spi_tx_data_o, m_rx});
            end
        end else if (!m_hold) begin
            m_cnt = m_cnt - 1;
            if (m_cnt <= 0) begin
                m_busy        = 1'b0;
                spi_done_i    = 1'b1;
                spi_rx_data_i = m_rx;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic rw, input logic [7:0] d);
        tx_wr_i = 1'b1; tx_rw_i = rw; tx_data_i = d;
        @(negedge clk_i);
        tx_wr_i = 1'b0;
    endtask

    task automatic pop_rx();
        rx_rd_i = 1'b1;
        @(negedge clk_i);
        rx_rd_i = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int i = 0;
        while ((busy_o || tx_level_o != 0) && i < maxc) begin
            @(negedge clk_i);
            i++;
        end
        check(name, 32'(i < maxc), 1);
    endtask

    // what=0: sequencer waiting for completion; what=1: launch request high
    task automatic wait_for(input int what, input int maxc, input string name);
        int i = 0;
        while (!((what == 0) ? (busy_o && !spi_start_o) : spi_start_o) && i < maxc) begin
            @(negedge clk_i);
            i++;
        end
        check(name, 32'(i < maxc), 1);
    endtask

    typedef struct {
        logic rw; logic [7:0] data; logic [7:0] rx; int lat;
        logic exp_empty; logic [7:0] exp_rx;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[5];
        launch_t    exp_cmds[$];
        launch_t    l, e;
        logic [7:0] exp_rx[$];
        logic [7:0] tmp;
        logic       rw;
        logic [7:0] d;
        int         k, cyc;

        vecs[0] = '{1'b0, 8'h69, 8'h00, 16, 1'b1, 8'h00};
        vecs[1] = '{1'b1, 8'hA5, 8'hFF, 16, 1'b0, 8'hFF};
        vecs[2] = '{1'b1, 8'h3C, 8'h5A,  1, 1'b0, 8'h5A};
        vecs[3] = '{1'b0, 8'hFF, 8'h11,  3, 1'b1, 8'h00};
        vecs[4] = '{1'b1, 8'h00, 8'h80,  7, 1'b0, 8'h80};

        rst_i = 1'b0; clr_i = 1'b0; tx_wr_i = 1'b0; tx_rw_i = 1'b0;
        tx_data_i = 8'h00; rx_rd_i = 1'b0;
        #1 rst_i = 1'b1;
        #1;
        check("rst_start", spi_start_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_rx_empty", rx_empty_o, 1);
        check("rst_level", tx_level_o, 0);
        check("rst_full", tx_full_o, 0);
        check("rst_ovf", rx_overflow_o, 0);
        check("rst_tmo", timeout_o, 0);
        check("rst_txdata", spi_tx_data_o, 0);
        check("rst_rw", spi_rw_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // ---- table-driven single transactions ----
        m_rx_mode = 0;
        for (int i = 0; i < 5; i++) begin
            m_fixed_rx = vecs[i].rx;
            m_lat      = vecs[i].lat;
            push(vecs[i].rw, vecs[i].data);
            wait_idle(200, "vec_done");
            check("vec_tx_data", spi_tx_data_o, vecs[i].data);
            check("vec_rw", spi_rw_o, vecs[i].rw);
            check("vec_rx_empty", rx_empty_o, vecs[i].exp_empty);
            if (!vecs[i].exp_empty) begin
                check("vec_rx_data", rx_data_o, vecs[i].exp_rx);
                pop_rx();
                check("vec_rx_drained", rx_empty_o, 1);
            end
        end

        // ---- async reset mid-START and mid-BUSY ----
        for (int mode = 0; mode < 2; mode++) begin
            m_noaccept = (mode == 0);
            m_hold     = (mode == 1);
            push(1'b1, 8'h5A);
            wait_for((mode == 0) ? 1 : 0, 50, "t1_reach");
            push(1'b0, 8'h01);
            push(1'b0, 8'h02);
            check("t1_busy_before", busy_o, 1);
            check("t1_start_before", spi_start_o, (mode == 0) ? 1 : 0);
            #2 rst_i = 1'b1;
            #1;
            check("t1_start", spi_start_o, 0);
            check("t1_busy", busy_o, 0);
            check("t1_rx_empty", rx_empty_o, 1);
            check("t1_level", tx_level_o, 0);
            repeat (2) @(negedge clk_i);
            rst_i = 1'b0; m_noaccept = 1'b0; m_hold = 1'b0;
            @(negedge clk_i);
        end

        // ---- TX full, RX overflow ----
        m_rx_mode = 2; m_lat = 3; m_hold = 1'b1;
        push(1'b1, 8'h10);
        wait_for(0, 50, "t4_busy");
        for (int i = 1; i <= DEPTH + 1; i++) push(1'b1, 8'(8'h10 + i));
        check("t4_full", tx_full_o, 1);
        check("t4_level", tx_level_o, DEPTH);
        m_hold = 1'b0;
        wait_idle(600, "t4_drain_done");
        check("t4_ovf", rx_overflow_o, 1);
        for (int i = 0; i < DEPTH; i++) begin
            tmp = 8'(8'h10 + i);
            tmp = ~tmp;
            check("t4_rx_nonempty", rx_empty_o, 0);
            check("t4_rx_data", rx_data_o, tmp);
            pop_rx();
        end
        check("t4_rx_empty", rx_empty_o, 1);
        check("t4_ovf_sticky", rx_overflow_o, 1);

        // ---- timeout ----
        m_rx_mode = 0; m_lat = 3; m_hold = 1'b1;
        push(1'b0, 8'h77);
        wait_for(1, 20, "t5_start");
        cyc = 0;
        while (!timeout_o && cyc < 3 * TIMEOUT) begin
            @(negedge clk_i);
            cyc++;
        end
        check("t5_cycles", cyc, TIMEOUT);
        check("t5_flag", timeout_o, 1);
        check("t5_idle", busy_o, 0);
        check("t5_start_low", spi_start_o, 0);
        push(1'b0, 8'h78);
        repeat (5) @(negedge clk_i);
        check("t5_waits_level", tx_level_o, 1);
        check("t5_waits_idle", busy_o, 0);
        m_hold = 1'b0;
        wait_idle(100, "t5_next_done");
        check("t5_next_data", spi_tx_data_o, 8'h78);
        check("t5_flag_sticky", timeout_o, 1);

        // ---- clear with simultaneous push ----
        m_hold = 1'b1; m_fixed_rx = 8'hEE;
        push(1'b1, 8'hA1); push(1'b1, 8'hA2); push(1'b1, 8'hA3); push(1'b1, 8'hA4);
        check("t6_level_pre", tx_level_o, 3);
        clr_i = 1'b1; tx_wr_i = 1'b1; tx_rw_i = 1'b1; tx_data_i = 8'hB0;
        @(negedge clk_i);
        clr_i = 1'b0; tx_wr_i = 1'b0;
        check("t6_level", tx_level_o, 0);
        check("t6_tmo", timeout_o, 0);
        check("t6_ovf", rx_overflow_o, 0);
        check("t6_busy", busy_o, 0);
        check("t6_start", spi_start_o, 0);
        m_hold = 1'b0;
        repeat (20) @(negedge clk_i);
        check("t6_no_capture", rx_empty_o, 1);
        check("t6_still_idle", busy_o, 0);

        // ---- randomized batches vs in-order model ----
        m_rx_mode = 1; m_rand_lat = 1'b1;
        launch_q.delete();
        for (int b = 0; b < 15; b++) begin
            k = $urandom_range(1, DEPTH);
            for (int j = 0; j < k; j++) begin
                rw = 1'($urandom);
                d  = 8'($urandom);
                exp_cmds.push_back('{rw, d, 8'h00});
                push(rw, d);
                if ($urandom_range(0, 1) == 1) @(negedge clk_i);
            end
            wait_idle(600, "rnd_done");
            check("rnd_launch_count", launch_q.size(), k);
            while (launch_q.size() > 0 && exp_cmds.size() > 0) begin
                l = launch_q.pop_front();
                e = exp_cmds.pop_front();
                check("rnd_cmd", {l.rw, l.data}, {e.rw, e.data});
                if (e.rw) exp_rx.push_back(l.rx);
            end
            launch_q.delete();
            exp_cmds.delete();
            while (exp_rx.size() > 0) begin
                tmp = exp_rx.pop_front();
                check("rnd_rx_nonempty", rx_empty_o, 0);
                check("rnd_rx_data", rx_data_o, tmp);
                pop_rx();
            end
            check("rnd_rx_empty", rx_empty_o, 1);
        end
        check("rnd_ovf", rx_overflow_o, 0);
        check("rnd_tmo", timeout_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
